// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap sequencer: accepts ecall/ebreak/mret/timer irq, writes mepc/mstatus/mcause, then redirects.
// Optional CSR_TRAP_VECTORED_EN enables vectored-mode interrupt targets from mtvec[1:0].
module csr_trap_ctrl #(
  parameter logic [31:0] CAUSE_ECALL  = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK = 32'd3,
  parameter logic [31:0] CAUSE_TIMER  = 32'h8000_0007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic [31:0] pc_i,
  input  logic        ex_csr_we_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, JUMP
  } state_t;

  state_t      state;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        is_mret;
  logic        take_irq;
  logic        accept;
  logic [31:0] trap_target;
  logic [31:0] mstatus_trap;
  logic [31:0] mstatus_ret;

  always_comb begin
    take_irq = irq_i & global_int_en_i;
    accept   = (state == IDLE) && (ecall_i || ebreak_i || mret_i || take_irq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cause   <= '0;
      epc     <= '0;
      is_mret <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ecall_i) begin
            cause   <= CAUSE_ECALL;
            epc     <= pc_i;
            is_mret <= 1'b0;
            state   <= W_MEPC;
          end else if (ebreak_i) begin
            cause   <= CAUSE_EBREAK;
            epc     <= pc_i;
            is_mret <= 1'b0;
            state   <= W_MEPC;
          end else if (mret_i) begin
            epc     <= pc_i;
            is_mret <= 1'b1;
            state   <= W_MRET;
          end else if (take_irq) begin
            cause   <= CAUSE_TIMER;
            epc     <= pc_i;
            is_mret <= 1'b0;
            state   <= W_MEPC;
          end
        end
        // Each write state holds while the execute stage owns the CSR write port.
        W_MEPC:    if (!ex_csr_we_i) state <= W_MSTATUS;
        W_MSTATUS: if (!ex_csr_we_i) state <= W_MCAUSE;
        W_MCAUSE:  if (!ex_csr_we_i) state <= JUMP;
        W_MRET:    if (!ex_csr_we_i) state <= JUMP;
        JUMP:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mstatus_trap    = csr_mstatus_i;
    mstatus_trap[7] = csr_mstatus_i[3];
    mstatus_trap[3] = 1'b0;
    mstatus_ret     = csr_mstatus_i;
    mstatus_ret[3]  = csr_mstatus_i[7];
    mstatus_ret[7]  = 1'b1;
    trap_target     = {csr_mtvec_i[31:2], 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
    if (csr_mtvec_i[1:0] == 2'b01 && cause[31])
      trap_target = {csr_mtvec_i[31:2], 2'b00} + {cause[29:0], 2'b00};
`endif
  end

`ifndef CSR_TRAP_VECTORED_EN
  logic unused_mode;
  assign unused_mode = ^csr_mtvec_i[1:0];
`endif

  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    hold_o       = accept || (state != IDLE);
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (state)
      W_MEPC: if (!ex_csr_we_i) begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 32'h0000_0341;
        csr_wdata_o = epc;
      end
      W_MSTATUS: if (!ex_csr_we_i) begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 32'h0000_0300;
        csr_wdata_o = mstatus_trap;
      end
      W_MCAUSE: if (!ex_csr_we_i) begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 32'h0000_0342;
        csr_wdata_o = cause;
      end
      W_MRET: if (!ex_csr_we_i) begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 32'h0000_0300;
        csr_wdata_o = mstatus_ret;
      end
      JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = is_mret ? csr_mepc_i : trap_target;
      end
      default: ;
    endcase
  end

endmodule
